// File: rtl/axi_wr_pkg.sv
// Shared definitions for the AXI write path: phase codes, route codes and the
// helper that builds a route code from a granted master/slave pair.
package axi_wr_pkg;

    typedef enum logic [1:0] {
        PH_IDLE = 2'b00,
        PH_ADDR = 2'b01,
        PH_DATA = 2'b10,
        PH_RESP = 2'b11
    } phase_e;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_ADDR = 2'b01;
    localparam logic [1:0] ST_DATA = 2'b10;
    localparam logic [1:0] ST_RESP = 2'b11;

    localparam logic [1:0] MASTER_M0 = 2'b00;
    localparam logic [1:0] MASTER_M1 = 2'b10;
    localparam logic [1:0] SLAVE_S0  = 2'b01;
    localparam logic [1:0] SLAVE_S1  = 2'b10;

    localparam logic [3:0] ROUTE_IDLE = 4'b0000;
    localparam logic [3:0] ROUTE_M0S0 = {MASTER_M0, SLAVE_S0};
    localparam logic [3:0] ROUTE_M0S1 = {MASTER_M0, SLAVE_S1};
    localparam logic [3:0] ROUTE_M1S0 = {MASTER_M1, SLAVE_S0};
    localparam logic [3:0] ROUTE_M1S1 = {MASTER_M1, SLAVE_S1};

    function automatic logic [3:0] route_code(input logic master, input logic slave);
        case ({master, slave})
            2'b00:   route_code = ROUTE_M0S0;
            2'b01:   route_code = ROUTE_M0S1;
            2'b10:   route_code = ROUTE_M1S0;
            default: route_code = ROUTE_M1S1;
        endcase
    endfunction

endpackage

// File: rtl/axi_write_arbiter_rr.sv
// Two-request round-robin grant; the pointer moves to the other master when a
// transaction completes.
module rr_arbiter2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       upd_i,
    input  logic       upd_master_i,
    output logic       gnt_valid_o,
    output logic       gnt_master_o
);

    logic prio_q;
    logic prio_d;

    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        prio_d = prio_q;
        if (upd_i) begin
            prio_d = ~upd_master_i;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

    assign gnt_valid_o  = |req_i;
    assign gnt_master_o = (&req_i) ? prio_q : req_i[1];

endmodule

// File: rtl/axi_write_arbiter.sv
// Write-path arbiter for a 2x2 AXI interconnect: grants one write at a time,
// holds the route from grant to B handshake and tracks the AW/W/B phases.
module axi_write_arbiter
    import axi_wr_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int SEL_BIT = 16,
    parameter int LEN_W   = 4
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              AWVALID_M0,
    input  logic              AWVALID_M1,
    input  logic [ADDR_W-1:0] AWADDR_M0,
    input  logic [ADDR_W-1:0] AWADDR_M1,
    input  logic [LEN_W-1:0]  AWLEN_M0,
    input  logic [LEN_W-1:0]  AWLEN_M1,
    input  logic              AWREADY_S0,
    input  logic              AWREADY_S1,
    input  logic              WVALID_M0,
    input  logic              WVALID_M1,
    input  logic              WLAST_M0,
    input  logic              WLAST_M1,
    input  logic              WREADY_S0,
    input  logic              WREADY_S1,
    input  logic              BVALID_S0,
    input  logic              BVALID_S1,
    input  logic              BREADY_M0,
    input  logic              BREADY_M1,
    output logic [3:0]        Arbiter_AWID_control,
    output logic [1:0]        Aibiter_Write_State_control,
    output logic              WLAST_ERR
);

    localparam int CNT_W = LEN_W + 1;

    logic [1:0]       state_q, state_d;
    logic             master_q, master_d;
    logic             slave_q, slave_d;
    logic [CNT_W-1:0] beats_q, beats_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             aw_done_q, aw_done_d;
    logic             last_done_q, last_done_d;
    logic [3:0]       route_q, route_d;
    logic             err_q, err_d;

    logic             gnt_valid, gnt_master, gnt_slave;
    logic [LEN_W-1:0] gnt_len;
    logic             aw_hs, w_hs, w_last, b_hs;
    logic [CNT_W-1:0] cnt_inc;

    // Only the slave-select bit of each address matters here.
    logic unused_addr;
    assign unused_addr = ^{AWADDR_M0, AWADDR_M1};

    rr_arbiter2 u_rr (
        .clk_i        (ACLK),
        .rst_i        (ARESET),
        .req_i        ({AWVALID_M1, AWVALID_M0}),
        .upd_i        ((state_q == ST_RESP) && b_hs),
        .upd_master_i (master_q),
        .gnt_valid_o  (gnt_valid),
        .gnt_master_o (gnt_master)
    );

    assign gnt_slave = gnt_master ? AWADDR_M1[SEL_BIT] : AWADDR_M0[SEL_BIT];
    assign gnt_len   = gnt_master ? AWLEN_M1 : AWLEN_M0;

    assign aw_hs  = (master_q ? AWVALID_M1 : AWVALID_M0) & (slave_q ? AWREADY_S1 : AWREADY_S0);
    assign w_hs   = (master_q ? WVALID_M1 : WVALID_M0) & (slave_q ? WREADY_S1 : WREADY_S0);
    assign w_last = master_q ? WLAST_M1 : WLAST_M0;
    assign b_hs   = (slave_q ? BVALID_S1 : BVALID_S0) & (master_q ? BREADY_M1 : BREADY_M0);

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        master_d    = master_q;
        slave_d     = slave_q;
        beats_d     = beats_q;
        cnt_d       = cnt_q;
        aw_done_d   = aw_done_q;
        last_done_d = last_done_q;
        route_d     = route_q;
        err_d       = err_q;

        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    master_d    = gnt_master;
                    slave_d     = gnt_slave;
                    beats_d     = {1'b0, gnt_len} + CNT_W'(1);
                    cnt_d       = '0;
                    aw_done_d   = 1'b0;
                    last_done_d = 1'b0;
                    route_d     = route_code(gnt_master, gnt_slave);
                    state_d     = ST_ADDR;
                end
            end
            ST_ADDR, ST_DATA: begin
                // W beats count from grant because the data mux is already routed.
                if (w_hs && !last_done_q) begin
                    cnt_d = cnt_inc;
                    if (w_last) begin
                        last_done_d = 1'b1;
                        if (cnt_inc != beats_q) begin
                            err_d = 1'b1;
                        end
                    end
                end
                if (aw_hs) begin
                    aw_done_d = 1'b1;
                end
                if (aw_done_d && last_done_d) begin
                    state_d = ST_RESP;
                end else if (aw_done_d) begin
                    state_d = ST_DATA;
                end
            end
            default: begin
                if (b_hs) begin
                    state_d = ST_IDLE;
                    route_d = ROUTE_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= ST_IDLE;
            master_q    <= 1'b0;
            slave_q     <= 1'b0;
            beats_q     <= '0;
            cnt_q       <= '0;
            aw_done_q   <= 1'b0;
            last_done_q <= 1'b0;
            route_q     <= ROUTE_IDLE;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            master_q    <= master_d;
            slave_q     <= slave_d;
            beats_q     <= beats_d;
            cnt_q       <= cnt_d;
            aw_done_q   <= aw_done_d;
            last_done_q <= last_done_d;
            route_q     <= route_d;
            err_q       <= err_d;
        end
    end

    assign Arbiter_AWID_control        = route_q;
    assign Aibiter_Write_State_control = state_q;
    assign WLAST_ERR                   = err_q;

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Directed bench: each stimulus step queues the expected {route, phase, err}
// change and its cycle; a negedge monitor pops and compares on every change.
module tb_axi_write_arbiter;

    logic        ACLK;
    logic        ARESET;
    logic        AWVALID_M0, AWVALID_M1;
    logic [31:0] AWADDR_M0, AWADDR_M1;
    logic [3:0]  AWLEN_M0, AWLEN_M1;
    logic        AWREADY_S0, AWREADY_S1;
    logic        WVALID_M0, WVALID_M1, WLAST_M0, WLAST_M1;
    logic        WREADY_S0, WREADY_S1;
    logic        BVALID_S0, BVALID_S1;
    logic        BREADY_M0, BREADY_M1;
    logic [3:0]  route;
    logic [1:0]  phase;
    logic        err;

    axi_write_arbiter #(.ADDR_W(32), .SEL_BIT(16), .LEN_W(4)) dut (
        .ACLK                        (ACLK),
        .ARESET                      (ARESET),
        .AWVALID_M0                  (AWVALID_M0),
        .AWVALID_M1                  (AWVALID_M1),
        .AWADDR_M0                   (AWADDR_M0),
        .AWADDR_M1                   (AWADDR_M1),
        .AWLEN_M0                    (AWLEN_M0),
        .AWLEN_M1                    (AWLEN_M1),
        .AWREADY_S0                  (AWREADY_S0),
        .AWREADY_S1                  (AWREADY_S1),
        .WVALID_M0                   (WVALID_M0),
        .WVALID_M1                   (WVALID_M1),
        .WLAST_M0                    (WLAST_M0),
        .WLAST_M1                    (WLAST_M1),
        .WREADY_S0                   (WREADY_S0),
        .WREADY_S1                   (WREADY_S1),
        .BVALID_S0                   (BVALID_S0),
        .BVALID_S1                   (BVALID_S1),
        .BREADY_M0                   (BREADY_M0),
        .BREADY_M1                   (BREADY_M1),
        .Arbiter_AWID_control        (route),
        .Aibiter_Write_State_control (phase),
        .WLAST_ERR                   (err)
    );

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  tag;
        logic [6:0]  val;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          tag = 0;
    logic [31:0] cyc = 0;
    logic        mon_en = 1'b0;
    logic [6:0]  prev = 7'b0;

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic check(input logic ok, input string name, input string got, input string want);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %s, expected %s", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Expected output change at the edge that samples the inputs now driven.
    task automatic exp_next(input logic [3:0] r, input logic [1:0] p, input logic e);
        exp_t x;
        x.cyc = cyc + 1;
        x.tag = 8'(tag);
        x.val = {r, p, e};
        exp_q.push_back(x);
    endtask

    task automatic clear_inputs();
        AWVALID_M0 = 0; AWVALID_M1 = 0;
        AWADDR_M0 = 0;  AWADDR_M1 = 0;
        AWLEN_M0 = 0;   AWLEN_M1 = 0;
        AWREADY_S0 = 0; AWREADY_S1 = 0;
        WVALID_M0 = 0;  WVALID_M1 = 0;
        WLAST_M0 = 0;   WLAST_M1 = 0;
        WREADY_S0 = 0;  WREADY_S1 = 0;
        BVALID_S0 = 0;  BVALID_S1 = 0;
        BREADY_M0 = 0;  BREADY_M1 = 0;
    endtask

    always @(negedge ACLK) begin
        if (mon_en) begin
            logic [6:0] cur;
            exp_t       e;
            cur = {route, phase, err};
            if (cur !== prev) begin
                check(exp_q.size() != 0, "unexpected_change",
                      $sformatf("cyc %0d rpe %b", cyc, cur), "no change");
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check((cur === e.val) && (cyc == e.cyc), $sformatf("t%0d_transition", e.tag),
                          $sformatf("cyc %0d route %b phase %b err %b", cyc, cur[6:3], cur[2:1], cur[0]),
                          $sformatf("cyc %0d route %b phase %b err %b", e.cyc, e.val[6:3], e.val[2:1], e.val[0]));
                end
                prev = cur;
            end
        end
    end

    initial begin
        clear_inputs();
        ARESET = 1;
        tick();
        tick();
        check(route === 4'b0000, "reset_route", $sformatf("%b", route), "0000");
        check(phase === 2'b00, "reset_phase", $sformatf("%b", phase), "00");
        check(err === 1'b0, "reset_err", $sformatf("%b", err), "0");
        ARESET = 0;
        mon_en = 1;
        tick();

        // t2: tie after reset -> M0, then M1 after one IDLE cycle, then M0 again
        tag = 2;
        AWVALID_M0 = 1; AWADDR_M0 = 32'h0000_0000; AWLEN_M0 = 0;
        AWVALID_M1 = 1; AWADDR_M1 = 32'h0001_0000; AWLEN_M1 = 0;
        exp_next(4'b0001, 2'b01, 0); tick();
        AWREADY_S0 = 1; WVALID_M0 = 1; WREADY_S0 = 1; WLAST_M0 = 1;
        exp_next(4'b0001, 2'b11, 0); tick();
        AWREADY_S0 = 0; WVALID_M0 = 0; WREADY_S0 = 0; WLAST_M0 = 0;
        BVALID_S0 = 1; BREADY_M0 = 1;
        exp_next(4'b0000, 2'b00, 0); tick();
        BVALID_S0 = 0; BREADY_M0 = 0;
        exp_next(4'b1010, 2'b01, 0); tick();
        AWREADY_S1 = 1; WVALID_M1 = 1; WREADY_S1 = 1; WLAST_M1 = 1;
        exp_next(4'b1010, 2'b11, 0); tick();
        AWREADY_S1 = 0; WVALID_M1 = 0; WREADY_S1 = 0; WLAST_M1 = 0;
        BVALID_S1 = 1; BREADY_M1 = 1;
        exp_next(4'b0000, 2'b00, 0); tick();
        BVALID_S1 = 0; BREADY_M1 = 0;
        exp_next(4'b0001, 2'b01, 0); tick();
        AWVALID_M1 = 0;
        AWREADY_S0 = 1; WVALID_M0 = 1; WREADY_S0 = 1; WLAST_M0 = 1;
        exp_next(4'b0001, 2'b11, 0); tick();
        clear_inputs();
        BVALID_S0 = 1; BREADY_M0 = 1;
        exp_next(4'b0000, 2'b00, 0); tick();
        clear_inputs(); tick();

        // t1: M0 -> S0, 4 beats, AWREADY one cycle after grant, B two cycles after RESP
        tag = 1;
        AWVALID_M0 = 1; AWADDR_M0 = 32'h0000_0100; AWLEN_M0 = 3;
        exp_next(4'b0001, 2'b01, 0); tick();
        AWREADY_S0 = 1;
        exp_next(4'b0001, 2'b10, 0); tick();
        AWVALID_M0 = 0; AWREADY_S0 = 0;
        WVALID_M0 = 1; WREADY_S0 = 1;
        for (int i = 0; i < 3; i++) tick();
        WLAST_M0 = 1;
        exp_next(4'b0001, 2'b11, 0); tick();
        clear_inputs(); tick();
        BVALID_S0 = 1; BREADY_M0 = 1;
        exp_next(4'b0000, 2'b00, 0); tick();
        clear_inputs(); tick();

        // t3: single-beat WLAST before the AW handshake -> ADDR straight to RESP
        tag = 3;
        AWVALID_M0 = 1; AWADDR_M0 = 32'h0001_0040; AWLEN_M0 = 0;
        exp_next(4'b0010, 2'b01, 0); tick();
        WVALID_M0 = 1; WREADY_S1 = 1; WLAST_M0 = 1; tick();
        WVALID_M0 = 0; WREADY_S1 = 0; WLAST_M0 = 0; AWREADY_S1 = 1;
        exp_next(4'b0010, 2'b11, 0); tick();
        clear_inputs();
        BVALID_S1 = 1; BREADY_M0 = 1;
        exp_next(4'b0000, 2'b00, 0); tick();
        clear_inputs(); tick();

        // t5: non-granted WREADY/BVALID/BREADY activity causes no change
        tag = 5;
        AWVALID_M0 = 1; AWADDR_M0 = 32'h0000_0200; AWLEN_M0 = 1;
        exp_next(4'b0001, 2'b01, 0); tick();
        AWREADY_S0 = 1;
        exp_next(4'b0001, 2'b10, 0); tick();
        AWVALID_M0 = 0; AWREADY_S0 = 0;
        WVALID_M0 = 1; WLAST_M0 = 1; WREADY_S1 = 1; tick();
        WREADY_S1 = 0; WLAST_M0 = 0; WREADY_S0 = 1; tick();
        WREADY_S1 = 1; WLAST_M0 = 1;
        exp_next(4'b0001, 2'b11, 0); tick();
        clear_inputs();
        BVALID_S1 = 1; BREADY_M0 = 1; tick();
        BVALID_S1 = 0; BVALID_S0 = 1; BREADY_M0 = 0; BREADY_M1 = 1; tick();
        BREADY_M1 = 0; BREADY_M0 = 1;
        exp_next(4'b0000, 2'b00, 0); tick();
        clear_inputs(); tick();

        // t4: M1 -> S0 with AWLEN=3 but WLAST on beat 2; error is sticky
        tag = 4;
        AWVALID_M1 = 1; AWADDR_M1 = 32'h0000_2000; AWLEN_M1 = 3;
        exp_next(4'b1001, 2'b01, 0); tick();
        AWREADY_S0 = 1;
        exp_next(4'b1001, 2'b10, 0); tick();
        AWVALID_M1 = 0; AWREADY_S0 = 0;
        WVALID_M1 = 1; WREADY_S0 = 1; tick();
        WLAST_M1 = 1;
        exp_next(4'b1001, 2'b11, 1); tick();
        clear_inputs();
        BVALID_S0 = 1; BREADY_M1 = 1;
        exp_next(4'b0000, 2'b00, 1); tick();
        clear_inputs(); tick();
        AWVALID_M0 = 1; AWADDR_M0 = 32'h0000_0300; AWLEN_M0 = 1;
        exp_next(4'b0001, 2'b01, 1); tick();
        AWREADY_S0 = 1;
        exp_next(4'b0001, 2'b10, 1); tick();
        AWVALID_M0 = 0; AWREADY_S0 = 0;
        WVALID_M0 = 1; WREADY_S0 = 1; tick();
        WLAST_M0 = 1;
        exp_next(4'b0001, 2'b11, 1); tick();
        clear_inputs();
        BVALID_S0 = 1; BREADY_M0 = 1;
        exp_next(4'b0000, 2'b00, 1); tick();
        clear_inputs(); tick();

        // t6: reset mid-burst, then a tie must go to M0 again
        tag = 6;
        AWVALID_M0 = 1; AWADDR_M0 = 32'h0000_0100; AWLEN_M0 = 3;
        exp_next(4'b0001, 2'b01, 1); tick();
        AWREADY_S0 = 1;
        exp_next(4'b0001, 2'b10, 1); tick();
        AWVALID_M0 = 0; AWREADY_S0 = 0;
        WVALID_M0 = 1; WREADY_S0 = 1; tick();
        clear_inputs();
        ARESET = 1;
        exp_next(4'b0000, 2'b00, 0); tick();
        ARESET = 0; tick();
        AWVALID_M0 = 1; AWADDR_M0 = 32'h0000_0000; AWLEN_M0 = 0;
        AWVALID_M1 = 1; AWADDR_M1 = 32'h0001_0000; AWLEN_M1 = 0;
        exp_next(4'b0001, 2'b01, 0); tick();
        AWVALID_M1 = 0;
        AWREADY_S0 = 1; WVALID_M0 = 1; WREADY_S0 = 1; WLAST_M0 = 1;
        exp_next(4'b0001, 2'b11, 0); tick();
        clear_inputs();
        BVALID_S0 = 1; BREADY_M0 = 1;
        exp_next(4'b0000, 2'b00, 0); tick();
        clear_inputs();
        tick(); tick(); tick();

        check(exp_q.size() == 0, "pending_expectations",
              $sformatf("%0d left", exp_q.size()), "0 left");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
